regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL expose parameter HOLD_LIMIT, default 3, meaning consecutive denied cycles before the buffer head wins the write port.
REQ-002 SHALL expose parameter BUF_DEPTH, default 2, meaning long-unit result buffer entries (power of two).
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 pipe_we / pipe_waddr / pipe_wdata  in  1/5/32  pipeline writeback request.
REQ-006 pipe_hold  out  1  pipeline writeback denied this cycle; pipeline SHALL hold its request.
REQ-007 lu_issue / lu_issue_addr  in  1/5  long-latency unit (div, uncached load) issues, with destination register.
REQ-008 issue_ok  out  1  issue accepted; low when the destination is busy.
REQ-009 lu_valid / lu_addr / lu_data  in  1/5/32  long-unit result offer; lu_ready  out  1  result accepted.
REQ-010 rf_we / rf_waddr / rf_wdata  out  1/5/32  register file write port, combinational.
REQ-011 chk1_addr, chk2_addr, chk3_addr  in  5 each; chk_en  in  3  decode-stage source and destination hazard checks.
REQ-012 stall  out  1  a checked register is pending.

Function
REQ-013 SHALL keep a 32-bit busy scoreboard; bit 0 never set.
REQ-014 issue_ok SHALL equal !busy[lu_issue_addr] || lu_issue_addr==0; an accepted issue SHALL set the busy bit next edge.
REQ-015 A busy bit SHALL clear on the edge where its long-unit result is written to the register file; if set and clear coincide on one address, set wins.
REQ-016 stall SHALL be high when any enabled chk address is nonzero and busy, or matches a buffered or offered result not yet written.
REQ-017 lu_ready SHALL equal buffer not full; a result is accepted when lu_valid && lu_ready.
REQ-018 Port priority each cycle: (a) buffer head if its hold counter == HOLD_LIMIT; (b) pipe_we; (c) buffer head; (d) lu result bypass if buffer empty; else idle.
REQ-019 An accepted lu result not written by bypass SHALL enqueue at the tail the same edge.
REQ-020 Hold counter SHALL increment each cycle the buffer is nonempty and its head is not written; reset to 0 when the head is written or the buffer empties; saturates at HOLD_LIMIT.
REQ-021 pipe_hold SHALL be high only under REQ-018(a) with pipe_we high.
REQ-022 Writes with address 0 SHALL drive rf_we=0 but still dequeue/clear normally.
REQ-023 Simultaneous dequeue and enqueue at full buffer SHALL NOT occur (lu_ready low); at non-full buffer both SHALL complete in one edge.
REQ-024 Pointers SHALL wrap modulo BUF_DEPTH with a separate count register.

Reset
REQ-025 On rst: busy=0, buffer count/pointers=0, hold counter=0; outputs rf_we=0, pipe_hold=0, stall=0, lu_ready=1, issue_ok=1 (given lu_issue_addr free).
REQ-026 Reset mid-operation SHALL discard buffered results without writing them.

Structure
REQ-027 Register address width, data width and zero-register constant SHALL come from the shared defines package.
REQ-028 The result buffer SHALL be a sub-module wb_fifo (parameterised depth, 37-bit entries).

Verification
REQ-029 Issue r5, then lu result r5=0x1234 with pipe idle -> rf_we=1, waddr=5, wdata=0x1234 same cycle; busy[5] clear next cycle.
REQ-030 Issue r5, chk1=r5 enabled -> stall=1 until the write edge; chk1=r0 -> stall=0.
REQ-031 pipe_we every cycle, two lu results -> both buffered, lu_ready=0; after 3 denied cycles pipe_hold=1 and head written.
REQ-032 Issue r7 while busy[7] -> issue_ok=0, scoreboard unchanged.
REQ-033 lu result to r0 -> rf_we=0, lu_ready=1, no stall.
REQ-034 rst asserted with 2 buffered entries -> count=0, no writes, busy=0 immediately.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared register-file widths, buffer entry layout and write-port selector
package regfile_wb_arbiter_pkg;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int EW = AW + DW;
    localparam logic [AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_entry_t;

    typedef enum logic [2:0] {
        SEL_IDLE,
        SEL_FORCED,
        SEL_PIPE,
        SEL_HEAD,
        SEL_BYPASS
    } wb_sel_e;
endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// wb_fifo: long-unit result buffer with head view and per-entry occupancy for hazard checks
// Ports: clk, rst (async, active-high); push/push_data enqueue at tail; pop dequeues head;
//        head, empty, full; entries (all slots flattened) and occupied (slot holds a live entry).
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W = 37
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [W-1:0]         push_data,
    input  logic                 pop,
    output logic [W-1:0]         head,
    output logic                 empty,
    output logic                 full,
    output logic [DEPTH*W-1:0]   entries,
    output logic [DEPTH-1:0]     occupied
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = count == '0;
    assign full  = count == CW'(DEPTH);

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        assign entries[g*W +: W] = mem[g];
        // a slot is live when its distance from the read pointer is below the fill count
        assign occupied[g] = CW'(PW'(g) - rd_ptr) < count;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates the register-file write port between the pipeline and a long-latency unit
// Ports: clk, rst (async, active-high)
//        pipe_we/pipe_waddr/pipe_wdata in, pipe_hold out   - pipeline writeback request
//        lu_issue/lu_issue_addr in, issue_ok out             - long-unit issue and scoreboard reservation
//        lu_valid/lu_addr/lu_data in, lu_ready out           - long-unit result offer
//        rf_we/rf_waddr/rf_wdata out                         - register file write port (combinational)
//        chk1_addr/chk2_addr/chk3_addr/chk_en in, stall out  - decode hazard checks
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int HOLD_LIMIT = 3,
    parameter int BUF_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_we,
    input  logic [AW-1:0] pipe_waddr,
    input  logic [DW-1:0] pipe_wdata,
    output logic          pipe_hold,
    input  logic          lu_issue,
    input  logic [AW-1:0] lu_issue_addr,
    output logic          issue_ok,
    input  logic          lu_valid,
    input  logic [AW-1:0] lu_addr,
    input  logic [DW-1:0] lu_data,
    output logic          lu_ready,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    input  logic [AW-1:0] chk1_addr,
    input  logic [AW-1:0] chk2_addr,
    input  logic [AW-1:0] chk3_addr,
    input  logic [2:0]    chk_en,
    output logic          stall
);
    localparam int HW = HOLD_LIMIT > 0 ? $clog2(HOLD_LIMIT + 1) : 1;

    logic [31:0]              busy, busy_nxt, pend, hz;
    logic [HW-1:0]            hold_cnt;
    logic                     buf_empty, buf_full, lu_acc, forced, push, pop;
    logic [EW-1:0]            head_raw;
    logic [BUF_DEPTH*EW-1:0]  entries;
    logic [BUF_DEPTH-1:0]     occupied;
    wb_entry_t                head, slot;
    wb_sel_e                  sel;

    wb_fifo #(.DEPTH(BUF_DEPTH), .W(EW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({lu_addr, lu_data}),
        .pop       (pop),
        .head      (head_raw),
        .empty     (buf_empty),
        .full      (buf_full),
        .entries   (entries),
        .occupied  (occupied)
    );

    assign head     = wb_entry_t'(head_raw);
    assign lu_ready = !buf_full;
    assign lu_acc   = lu_valid && lu_ready;
    assign forced   = !buf_empty && hold_cnt == HW'(HOLD_LIMIT);
    assign sel      = forced ? SEL_FORCED :
                      pipe_we ? SEL_PIPE :
                      !buf_empty ? SEL_HEAD :
                      lu_acc ? SEL_BYPASS : SEL_IDLE;
    assign pop       = sel == SEL_FORCED || sel == SEL_HEAD;
    assign push      = lu_acc && sel != SEL_BYPASS;
    assign pipe_hold = forced && pipe_we;

    // writes to r0 still retire a buffered entry but never reach the register file
    always_comb begin
        rf_waddr = pop ? head.addr : sel == SEL_PIPE ? pipe_waddr : lu_addr;
        rf_wdata = pop ? head.data : sel == SEL_PIPE ? pipe_wdata : lu_data;
        rf_we    = sel != SEL_IDLE && rf_waddr != ZERO_REG;
    end

    assign issue_ok = !busy[lu_issue_addr] || lu_issue_addr == ZERO_REG;

    // clear first so a same-address issue on the retiring edge keeps the bit set
    always_comb begin
        busy_nxt = busy;
        if (pop || sel == SEL_BYPASS) busy_nxt[rf_waddr] = 1'b0;
        if (lu_issue && issue_ok) busy_nxt[lu_issue_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        pend = '0;
        slot = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            slot = wb_entry_t'(entries[i*EW +: EW]);
            if (occupied[i]) pend[slot.addr] = 1'b1;
        end
        if (lu_valid) pend[lu_addr] = 1'b1;
        hz = (busy | pend) & ~32'd1;
        stall = |(chk_en & {hz[chk3_addr], hz[chk2_addr], hz[chk1_addr]});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            hold_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            hold_cnt <= (buf_empty || pop) ? '0 :
                        hold_cnt == HW'(HOLD_LIMIT) ? hold_cnt : hold_cnt + HW'(1);
        end
    end
endmodule
